// File: rtl/ipsxe_floating_point_pipe_drain_v1_0_pkg.sv
// Shared helpers for the pipe-drain block: sizing function, parameter legality, event bundle.
package ipsxe_floating_point_pipe_drain_v1_0_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit legal_depth(input int depth);
        return is_pow2(depth) && (depth >= 2);
    endfunction

    function automatic bit legal_delay(input int delay_num);
        return delay_num >= 1;
    endfunction

    // Per-cycle handshake events, already qualified by the clock enable.
    typedef struct packed {
        logic issue;
        logic capture;
        logic pop;
    } drain_evt_t;

endpackage

// File: rtl/ipsxe_floating_point_drain_fifo_v1_0.sv
// FWFT result FIFO: write/read strobes arrive pre-gated by the clock enable; head visible the cycle after write.
// With IPSXE_FLOATING_POINT_DRAIN_DIAG_EN: exposes the count and a sticky overflow flag; writes at full are dropped.
module ipsxe_floating_point_drain_fifo_v1_0
    import ipsxe_floating_point_pipe_drain_v1_0_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [N-1:0]                i_wr_data,
    input  logic                        i_rd,
    output logic                        o_vld,
    output logic [N-1:0]                o_rd_data
`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
    ,
    output logic [clog2(DEPTH+1)-1:0]   o_count,
    output logic                        o_overflow
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
    logic full;
    logic overflow_q, overflow_d;

    assign full       = (count_q == CW'(DEPTH));
    assign wr_ok      = i_wr & ~full;
    assign overflow_d = overflow_q | (i_wr & full);
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end
`else
    // Credit accounting upstream guarantees a free slot for every capture.
    assign wr_ok = i_wr;
`endif

    assign rd_ok = i_rd & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= i_wr_data;
            end
        end
    end

    assign o_vld     = (count_q != '0);
    assign o_rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/ipsxe_floating_point_pipe_drain_v1_0.sv
// Drain for a fixed-latency FP datapath: credit issue, in-flight tracking, FWFT output; issue-to-valid DELAY_NUM+1 enabled cycles.
// Backpressure via registered credit (o_in_ready); optional diagnostics under IPSXE_FLOATING_POINT_DRAIN_DIAG_EN.
module ipsxe_floating_point_pipe_drain_v1_0
    import ipsxe_floating_point_pipe_drain_v1_0_pkg::*;
#(
    parameter int N         = 64,
    parameter int DELAY_NUM = 4,
    parameter int DEPTH     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_aclken,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [N-1:0]                i_pipe_data,
    output logic                        o_m_valid,
    input  logic                        i_m_ready,
    output logic [N-1:0]                o_m_data
`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
    ,
    output logic [clog2(DEPTH+1)-1:0]   o_level,
    output logic                        o_overflow
`endif
);

    localparam int CW = clog2(DEPTH + 1);

    if (!legal_depth(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (!legal_delay(DELAY_NUM)) begin : g_bad_delay
        $error("DELAY_NUM must be at least 1");
    end

    logic [DELAY_NUM-1:0] track_q, track_d;
    logic [CW-1:0]        occ_q, occ_d;
    drain_evt_t           evt;
    logic                 fifo_vld;

    // Credit counts in-flight plus stored results, so a capture always finds room.
    assign o_in_ready = (occ_q < CW'(DEPTH));
    assign o_m_valid  = fifo_vld;

    always_comb begin
        evt         = '0;
        evt.issue   = i_aclken & i_in_valid & o_in_ready;
        evt.capture = i_aclken & track_q[DELAY_NUM-1];
        evt.pop     = i_aclken & fifo_vld & i_m_ready;
        track_d     = track_q;
        occ_d       = occ_q;
        if (i_aclken) begin
            track_d = (track_q << 1) | DELAY_NUM'(evt.issue);
            occ_d   = occ_q + CW'(evt.issue) - CW'(evt.pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            track_q <= '0;
            occ_q   <= '0;
        end else begin
            track_q <= track_d;
            occ_q   <= occ_d;
        end
    end

    ipsxe_floating_point_drain_fifo_v1_0 #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr       (evt.capture),
        .i_wr_data  (i_pipe_data),
        .i_rd       (evt.pop),
        .o_vld      (fifo_vld),
        .o_rd_data  (o_m_data)
`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
        ,
        .o_count    (o_level),
        .o_overflow (o_overflow)
`endif
    );

endmodule

// File: tb/tb_ipsxe_floating_point_pipe_drain_v1_0.sv
// Directed bench with a datapath delay-line model and an in-order result scoreboard.
module tb_ipsxe_floating_point_pipe_drain_v1_0;

    localparam int N     = 64;
    localparam int DLY   = 4;
    localparam int DEPTH = 8;
    localparam logic [N-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         aclken;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] pipe_data;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
    logic [3:0]   level;
    logic         overflow;
`endif

    always #5 clk = ~clk;

    ipsxe_floating_point_pipe_drain_v1_0 #(
        .N         (N),
        .DELAY_NUM (DLY),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_aclken    (aclken),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_pipe_data (pipe_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data)
`ifdef IPSXE_FLOATING_POINT_DRAIN_DIAG_EN
        ,
        .o_level     (level),
        .o_overflow  (overflow)
`endif
    );

    // Bench-side datapath model and scoreboard state.
    bit           dl_vld [DLY];
    logic [N-1:0] dl_dat [DLY];
    logic [N-1:0] exp_q [$];
    int           m_fifo = 0;
    int           m_occ  = 0;
    logic [N-1:0] next_val = '0;
    int           n_chk  = 0;
    int           n_pass = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare at negedge, then advance the models after the posedge.
    task automatic tick();
        bit issue, pop, cap;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(m_occ < DEPTH));
        check("m_valid", 64'(m_valid), 64'(m_fifo != 0));
        if (m_fifo != 0) check("m_data", m_data, exp_q[0]);
        issue = aclken && in_valid && (m_occ < DEPTH);
        pop   = aclken && m_ready && (m_fifo != 0);
        cap   = aclken && dl_vld[DLY-1];
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (issue) exp_q.push_back(next_val);
        if (aclken) begin
            for (int i = DLY - 1; i > 0; i--) begin
                dl_vld[i] = dl_vld[i-1];
                dl_dat[i] = dl_dat[i-1];
            end
            dl_vld[0] = issue;
            dl_dat[0] = next_val;
        end
        if (issue) next_val = next_val + 1;
        m_fifo = m_fifo + int'(cap) - int'(pop);
        m_occ  = m_occ + int'(issue) - int'(pop);
        pipe_data = dl_vld[DLY-1] ? dl_dat[DLY-1] : JUNK;
    endtask

    // Assert reset just after an edge, check outputs at once, release mid-cycle.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_m_data", m_data, 64'd0);
        exp_q.delete();
        m_fifo = 0;
        m_occ  = 0;
        for (int i = 0; i < DLY; i++) begin
            dl_vld[i] = 1'b0;
            dl_dat[i] = '0;
        end
        pipe_data = JUNK;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        aclken    = 1'b1;
        in_valid  = 1'b0;
        m_ready   = 1'b1;
        pipe_data = JUNK;
        do_reset();
        repeat (4) tick();

        // Single operation, result visible DLY+1 cycles after issue.
        next_val = 64'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();

        // Backpressure: credit exhausts at DEPTH, then drain in order.
        next_val = 64'h1;
        m_ready  = 1'b0;
        in_valid = 1'b1;
        repeat (12) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        m_ready = 1'b1;
        repeat (10) tick();

        // Streaming across pointer wrap.
        next_val = 64'h100;
        in_valid = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (8) tick();

        // Streaming with the clock enable toggling.
        next_val = 64'h200;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            aclken = (i % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            aclken = (i % 2 == 1);
            tick();
        end
        aclken = 1'b1;
        repeat (4) tick();

        // Reset with two stored and three in flight.
        next_val = 64'h300;
        m_ready  = 1'b0;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        do_reset();
        m_ready = 1'b1;
        repeat (10) tick();

        // Fresh traffic after reset.
        next_val = 64'h400;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("drained", 64'(exp_q.size()), 64'd0);

        if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ipsxe_floating_point_pipe_drain_v1_0.md
Name: ipsxe_floating_point_pipe_drain_v1_0

Overview:
- Consumer end of a fixed-latency floating-point datapath.
- Issues input credit (o_in_ready) and tracks which issued operations are still in flight through the DELAY_NUM-stage datapath.
- Captures each datapath result as it emerges into a small FIFO, then presents it on a valid/ready master interface.
- Turns a stall-free fixed-latency pipeline into a back-pressurable stream without ever dropping a result.

Parameters:
- N, 64: result width in bits.
- DELAY_NUM, 4: datapath latency in enabled cycles; ≥1.
- DEPTH, 8: FIFO entries; power of two; ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_aclken  in  1  global clock enable; all state holds when low.
- i_in_valid  in  1  upstream presents an operation to the datapath.
- o_in_ready  out  1  credit available; an operation is issued when i_in_valid & o_in_ready & i_aclken.
- i_pipe_data  in  N  datapath output; valid exactly DELAY_NUM enabled cycles after issue.
- o_m_valid  out  1  FIFO non-empty.
- i_m_ready  in  1  downstream accepts.
- o_m_data  out  N  FIFO head.

Behaviour:
- Reset (async assert, sync release):
  - o_m_valid=0, o_m_data=0, o_in_ready=1.
  - Occupancy=0, pointers=0, valid-tracking shift register cleared, storage cleared.
- Clock enable:
  - All events (issue, capture, pop) occur only in cycles with i_aclken=1.
  - With i_aclken=0, every register holds, including the tracking shift register.
- Valid tracking:
  - A DELAY_NUM-bit shift register advances on each enabled cycle; bit 0 loads the issue event.
  - When bit DELAY_NUM-1 is 1, i_pipe_data is written to FIFO tail in that cycle.
- Credit:
  - occ = in-flight count + FIFO count, width clog2(DEPTH+1).
  - occ_next = occ + issue - pop.
  - o_in_ready = (occ < DEPTH), decoded from registered occ only; no combinational path from i_m_ready or i_in_valid.
  - A pop at occ=DEPTH raises o_in_ready in the next cycle.
- Output: first-word-fall-through.
  - o_m_valid = FIFO count≠0.
  - o_m_data = storage[rd_ptr].
  - Pop on o_m_valid & i_m_ready & i_aclken.
  - o_m_data stays stable while o_m_valid=1 and no pop occurs.
- Same-cycle capture into an empty FIFO: o_m_valid rises the next cycle; no bypass.
- Same-cycle capture and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- Capture never meets a full FIFO by construction of the credit scheme.
- Reset mid-operation discards all in-flight and stored results. Upstream must also reset the datapath.
- Throughput: with i_m_ready=1, one result per enabled cycle sustained. Latency from issue to o_m_valid is DELAY_NUM+1 enabled cycles.

Optional Feature:
- Macro IPSXE_FLOATING_POINT_DRAIN_DIAG_EN.
- Defined: adds outputs o_level [clog2(DEPTH+1)-1:0] (registered FIFO count) and o_overflow (sticky).
  - o_overflow sets if a capture occurs while FIFO count==DEPTH; it is cleared only by reset.
  - The offending write is dropped.
- Undefined: ports absent; no overflow logic.

Decomposition:
- Shared package: clog2 constant function; DEPTH/DELAY_NUM legality checks (elaboration-time error on DEPTH non-power-of-two or DELAY_NUM<1).
- Sub-module ipsxe_floating_point_drain_fifo_v1_0 holds storage, pointers, count and FWFT read. The top level holds the tracking shift register and credit counter.

Test Plan:
- Reset then idle: o_in_ready=1, o_m_valid=0, o_m_data=0. Release reset mid-clock; no spurious capture.
- Issue 1 op at t0, i_pipe_data=0xA5 at t0+4, i_m_ready=1: o_m_valid=1, o_m_data=0xA5 at t0+5 for one cycle.
- i_m_ready=0, continuous i_in_valid: exactly 8 issues accepted, then o_in_ready=0. All 8 results (0x1..0x8) are stored. Then i_m_ready=1: outputs 0x1..0x8 in order, and o_in_ready returns 1 the cycle after the first pop.
- Streaming with i_m_ready=1, 20 ops: one result per cycle, no bubbles, values in order across pointer wrap.
- i_aclken toggled 1/0 alternately during streaming: outputs identical to the ungated run, shifted in time. No state change in i_aclken=0 cycles.
- Assert i_rst_n low with 3 ops in flight and 2 stored: o_m_valid=0 immediately. After release, o_in_ready=1 and no stale results appear.
